// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the counters library
//
// Purpose : direction encodings used by every up/down counter, plus a
//           ceil(log2) helper so a caller can size WIDTH from a MODULUS.
// Contents: DIR_UP / DIR_DN  - values driven onto up_dn
//           clog2(value)     - bits needed to hold 0..value-1 (minimum 1)

package counter_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Returns the number of bits needed to represent 0..value-1.
   // A counter always has at least one bit, so small inputs return 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((value - 1) >> i != 0) begin
            result = i + 1;
         end
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

endpackage : counter_pkg

// File: rtl/t_ff_cell.sv
// rtl/t_ff_cell.sv - one-bit toggle flip-flop cell
//
// Purpose : storage element of the toggle-cell counters. The cell flips its
//           state on every rising edge where t is high.
// Ports   : clk            in  rising-edge clock
//           reset_negative in  asynchronous reset, active-low, clears q
//           t              in  toggle request
//           q              out current cell state

module t_ff_cell (
   input  logic clk,
   input  logic reset_negative,
   input  logic t,
   output logic q
);

   logic q_q;

   always_ff @(posedge clk or negedge reset_negative) begin
      if (!reset_negative) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_q ^ t;
      end
   end

   assign q = q_q;

endmodule : t_ff_cell

// File: rtl/tff_mod_counter.sv
// rtl/tff_mod_counter.sv - modulo-N up/down counter built from toggle cells
//
// Purpose : general-purpose counter for timers, dividers and address
//           generators. Counts 0..MODULUS-1 in either direction with
//           synchronous clear, clamped parallel load and count enable.
//           Stages cascade by feeding tc of one stage into en of the next.
// Params  : WIDTH   - counter width in bits (>= 1)
//           MODULUS - count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
// Ports   : clk            in  rising-edge clock
//           reset_negative in  asynchronous reset, active-low
//           sync_clr       in  synchronous clear, highest synchronous priority
//           load           in  synchronous load of load_val (clamped)
//           load_val       in  value to load
//           en             in  count enable
//           up_dn          in  1 = count up, 0 = count down
//           count          out current count, registered
//           tc             out terminal count, combinational
//           wrap           out registered one-cycle pulse with a wrapped count

module tff_mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 2 ** WIDTH
) (
   input  logic             clk,
   input  logic             reset_negative,
   input  logic             sync_clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_dn,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ZERO_C = '0;
   localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] toggle;
   logic             wrap_q;
   logic             wrap_d;
   logic             count_oor;
   logic             load_oor;
   logic             at_top;
   logic             at_bottom;

   // Range checks only exist when the modulus leaves unused binary codes;
   // with a full binary range every code is legal and nothing can be clamped.
   generate
      if (MODULUS < (2 ** WIDTH)) begin : g_partial_range
         assign count_oor = (count_q > MAX_C);
         assign load_oor  = (load_val > MAX_C);
      end else begin : g_full_range
         assign count_oor = 1'b0;
         assign load_oor  = 1'b0;
      end
   endgenerate

   // An illegal count is treated as a wrap point in both directions, so it
   // falls back into range on the next enabled step.
   assign at_top    = (count_q == MAX_C) || count_oor;
   assign at_bottom = (count_q == ZERO_C) || count_oor;

   // Next-state selection in priority order: clear, load, count, hold.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (sync_clr) begin
         count_d = ZERO_C;
      end else if (load) begin
         count_d = load_oor ? MAX_C : load_val;
      end else if (en) begin
         if (up_dn == DIR_UP) begin
            if (at_top) begin
               count_d = ZERO_C;
               wrap_d  = 1'b1;
            end else begin
               count_d = count_q + ONE_C;
            end
         end else begin
            if (at_bottom) begin
               count_d = MAX_C;
               wrap_d  = 1'b1;
            end else begin
               count_d = count_q - ONE_C;
            end
         end
      end
   end

   // Each cell toggles exactly the bits that differ between now and next.
   assign toggle = count_q ^ count_d;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_cell
         t_ff_cell u_cell (
            .clk            (clk),
            .reset_negative (reset_negative),
            .t              (toggle[i]),
            .q              (count_q[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_negative) begin
      if (!reset_negative) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   // Combinational so that a following stage sees it as its enable in the
   // same cycle; suppressed whenever clear or load overrides counting.
   assign tc = en & ~sync_clr & ~load &
               (((up_dn == DIR_UP) & (count_q == MAX_C)) |
                ((up_dn == DIR_DN) & (count_q == ZERO_C)));

   assign count = count_q;
   assign wrap  = wrap_q;

endmodule : tff_mod_counter

// File: tb/tb_tff_mod_counter.sv
// tb/tb_tff_mod_counter.sv - self-checking bench for tff_mod_counter

module tb_tff_mod_counter;

   logic       clk = 1'b0;
   logic       rstn;
   logic       sync_clr;
   logic       load;
   logic [3:0] load_val;
   logic       en;
   logic       up_dn;
   logic [3:0] count;
   logic       tc;
   logic       wrap;

   logic       c_en;
   logic       c_up;
   logic [2:0] lo_count;
   logic       lo_tc;
   logic       lo_wrap;
   logic [2:0] hi_count;
   logic       hi_tc;
   logic       hi_wrap;

   int checks = 0;
   int passed = 0;
   bit cmp_en = 1'b0;

   int m_cnt, m_wrap, m_lo, m_lo_wrap, m_hi, m_hi_wrap;

   always #5 clk = ~clk;

   tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .clk(clk), .reset_negative(rstn), .sync_clr(sync_clr), .load(load),
      .load_val(load_val), .en(en), .up_dn(up_dn),
      .count(count), .tc(tc), .wrap(wrap)
   );

   tff_mod_counter #(.WIDTH(3), .MODULUS(8)) u_lo (
      .clk(clk), .reset_negative(rstn), .sync_clr(1'b0), .load(1'b0),
      .load_val(3'd0), .en(c_en), .up_dn(c_up),
      .count(lo_count), .tc(lo_tc), .wrap(lo_wrap)
   );

   tff_mod_counter #(.WIDTH(3), .MODULUS(8)) u_hi (
      .clk(clk), .reset_negative(rstn), .sync_clr(1'b0), .load(1'b0),
      .load_val(3'd0), .en(lo_tc), .up_dn(c_up),
      .count(hi_count), .tc(hi_tc), .wrap(hi_wrap)
   );

   // Reference model: plain modular arithmetic on integers.
   function automatic int model_next(int c, int md, bit clr, bit ld, int lv, bit e, bit up);
      if (clr) return 0;
      if (ld) return (lv < md) ? lv : md - 1;
      if (!e) return c;
      if (up) return (c + 1) % md;
      return (c + md - 1) % md;
   endfunction

   function automatic int model_wrap(int c, int md, bit clr, bit ld, bit e, bit up);
      if (clr || ld || !e) return 0;
      if (up) return (c + 1 == md) ? 1 : 0;
      return (c == 0) ? 1 : 0;
   endfunction

   function automatic int model_tc(int c, int md, bit clr, bit ld, bit e, bit up);
      if (clr || ld || !e) return 0;
      if (up) return (c == md - 1) ? 1 : 0;
      return (c == 0) ? 1 : 0;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_cnt <= 0; m_wrap <= 0;
         m_lo  <= 0; m_lo_wrap <= 0;
         m_hi  <= 0; m_hi_wrap <= 0;
      end else begin
         m_cnt     <= model_next(m_cnt, 10, sync_clr, load, int'(load_val), en, up_dn);
         m_wrap    <= model_wrap(m_cnt, 10, sync_clr, load, en, up_dn);
         m_lo      <= model_next(m_lo, 8, 1'b0, 1'b0, 0, c_en, c_up);
         m_lo_wrap <= model_wrap(m_lo, 8, 1'b0, 1'b0, c_en, c_up);
         m_hi      <= model_next(m_hi, 8, 1'b0, 1'b0, 0,
                                 model_tc(m_lo, 8, 1'b0, 1'b0, c_en, c_up) != 0, c_up);
         m_hi_wrap <= model_wrap(m_hi, 8, 1'b0, 1'b0,
                                 model_tc(m_lo, 8, 1'b0, 1'b0, c_en, c_up) != 0, c_up);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every falling edge: all DUT outputs against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model count", int'(count), m_cnt);
         check("model wrap", int'(wrap), m_wrap);
         check("model tc", int'(tc), model_tc(m_cnt, 10, sync_clr, load, en, up_dn));
         check("model lo count", int'(lo_count), m_lo);
         check("model lo wrap", int'(lo_wrap), m_lo_wrap);
         check("model lo tc", int'(lo_tc), model_tc(m_lo, 8, 1'b0, 1'b0, c_en, c_up));
         check("model hi count", int'(hi_count), m_hi);
         check("model hi wrap", int'(hi_wrap), m_hi_wrap);
         check("model hi tc", int'(hi_tc),
               model_tc(m_hi, 8, 1'b0, 1'b0, lo_tc, c_up));
      end
   end

   // Inputs change 1 time unit after a rising edge, well clear of both edges.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int exp2[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
   int exp3[4]  = '{1, 0, 9, 8};
   int exp6[9]  = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

   initial begin
      rstn = 1'b0; sync_clr = 1'b0; load = 1'b0; load_val = 4'd0;
      en = 1'b0; up_dn = 1'b1; c_en = 1'b0; c_up = 1'b1;
      step();
      step();
      check("reset count", int'(count), 0);
      check("reset wrap", int'(wrap), 0);
      rstn = 1'b1;
      cmp_en = 1'b1;

      // T1: count to 7, then asynchronous reset between edges
      en = 1'b1; up_dn = 1'b1;
      repeat (7) step();
      check("T1 count 7", int'(count), 7);
      rstn = 1'b0;
      #1;
      check("T1 async count", int'(count), 0);
      check("T1 async wrap", int'(wrap), 0);
      repeat (3) begin
         step();
         check("T1 hold in reset", int'(count), 0);
      end
      en = 1'b0;
      rstn = 1'b1;

      // T2: up count with wrap 9 -> 0
      en = 1'b1; up_dn = 1'b1;
      for (int i = 0; i < 11; i++) begin
         step();
         check("T2 count", int'(count), exp2[i]);
         check("T2 wrap", int'(wrap), (i == 9) ? 1 : 0);
         check("T2 tc", int'(tc), (exp2[i] == 9) ? 1 : 0);
      end

      // T3: load 2, count down through 0 -> 9
      en = 1'b0; load = 1'b1; load_val = 4'd2;
      step();
      check("T3 load", int'(count), 2);
      load = 1'b0; en = 1'b1; up_dn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("T3 count", int'(count), exp3[i]);
         check("T3 wrap", int'(wrap), (i == 2) ? 1 : 0);
         check("T3 tc", int'(tc), (exp3[i] == 0) ? 1 : 0);
      end

      // T4: clear beats load beats count; load masks tc
      en = 1'b0; load = 1'b1; load_val = 4'd5;
      step();
      check("T4 preload", int'(count), 5);
      sync_clr = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1; up_dn = 1'b1;
      step();
      check("T4 clear wins", int'(count), 0);
      sync_clr = 1'b0; up_dn = 1'b0;
      #1;
      check("T4 tc masked by load", int'(tc), 0);
      step();
      check("T4 load wins", int'(count), 7);
      check("T4 wrap after load", int'(wrap), 0);

      // T5: clamp, hold, direction flip every edge
      load = 1'b1; load_val = 4'd13; en = 1'b0;
      step();
      check("T5 clamp", int'(count), 9);
      load = 1'b0;
      repeat (4) begin
         step();
         check("T5 hold count", int'(count), 9);
         check("T5 hold wrap", int'(wrap), 0);
      end
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         up_dn = (i % 2 == 0) ? 1'b1 : 1'b0;
         step();
         check("T5 flip count", int'(count), (i % 2 == 0) ? 0 : 9);
         check("T5 flip wrap", int'(wrap), 1);
      end
      en = 1'b0;

      // T6: full binary range and two-stage cascade
      c_en = 1'b1; c_up = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         check("T6 lo count", int'(lo_count), exp6[i]);
         check("T6 hi count", int'(hi_count), (i >= 7) ? 1 : 0);
      end
      repeat (15) step();
      check("T6 lo after 24", int'(lo_count), 0);
      check("T6 hi after 24", int'(hi_count), 3);
      c_up = 1'b0;
      step();
      check("T6 lo down", int'(lo_count), 7);
      check("T6 hi borrow", int'(hi_count), 2);
      c_en = 1'b0;
      step();

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_tff_mod_counter
